// File: rtl/trace_if.sv
// Word-serial trace stream: one 32-bit word per valid/ready handshake,
// with out_last marking the final word of each 4-word record.
interface trace_if;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;

    modport master (output out_valid, output out_data, output out_last, input out_ready);
    modport slave  (input out_valid, input out_data, input out_last, output out_ready);
endinterface

// File: rtl/trace_buffer.sv
// Commit-trace capture FIFO: samples {pc, ins, alures, data} records and
// streams them out one 32-bit word at a time, counting records it must drop.
module trace_buffer #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cap_en,
    input  logic [31:0]                pc_in,
    input  logic [31:0]                ins_in,
    input  logic [31:0]                alures_in,
    input  logic [31:0]                data_in,
    trace_if.master                    trace,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic [CNT_W-1:0]           drop_cnt,
    input  logic                       clr_ovf
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic {EMPTY, STREAM} state_e;

    state_e          state;
    logic [PW-1:0]   wp;
    logic [PW-1:0]   rp;
    logic [1:0]      widx;
    logic [127:0]    mem [DEPTH];

    logic            hs;
    logic            pop;
    logic            room;
    logic            push;
    logic            drop;
    logic [CW-1:0]   cnt_nxt;
    logic [127:0]    head;

    // A pop in the same cycle frees a slot, so a full buffer still accepts.
    always_comb begin
        hs      = trace.out_valid & trace.out_ready;
        pop     = hs & (widx == 2'd3);
        room    = (count < CW'(DEPTH)) | pop;
        push    = cap_en & room;
        drop    = cap_en & ~room;
        cnt_nxt = count;
        if (push && !pop) begin
            cnt_nxt = count + CW'(1);
        end else if (pop && !push) begin
            cnt_nxt = count - CW'(1);
        end
    end

    // Output word decode from registered state and the head record.
    always_comb begin
        head            = mem[rp];
        trace.out_valid = (state == STREAM);
        trace.out_last  = trace.out_valid & (widx == 2'd3);
        case (widx)
            2'd0:    trace.out_data = head[127:96];
            2'd1:    trace.out_data = head[95:64];
            2'd2:    trace.out_data = head[63:32];
            default: trace.out_data = head[31:0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wp] <= {pc_in, ins_in, alures_in, data_in};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            wp       <= '0;
            rp       <= '0;
            widx     <= 2'd0;
            count    <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            count <= cnt_nxt;
            state <= (cnt_nxt != '0) ? STREAM : EMPTY;
            if (push) begin
                wp <= wp + PW'(1);
            end
            if (hs) begin
                widx <= widx + 2'd1;
            end
            if (pop) begin
                rp <= rp + PW'(1);
            end
            // A drop in the clearing cycle still registers as the first drop.
            if (drop) begin
                overflow <= 1'b1;
                if (clr_ovf) begin
                    drop_cnt <= CNT_W'(1);
                end else if (drop_cnt != '1) begin
                    drop_cnt <= drop_cnt + CNT_W'(1);
                end
            end else if (clr_ovf) begin
                overflow <= 1'b0;
                drop_cnt <= '0;
            end
        end
    end

endmodule
